floating_alu_pipe: RTL and testbench
====================================

# floating_alu_pipe

Pipelined single-precision floating-point ALU functional unit for the execution stage. It accepts one non-arithmetic FP micro-operation per cycle from issue, in `to_execution` format. Supported operations are sign-injection, min/max, compare, classify and move. Each result returns on `ex_update` after a fixed, parametrised latency, with a flush path for misprediction recovery.

## Interface
- `INSTR_BITS`, 32: instruction width, kept for struct compatibility.
- `LATENCY`, 2: pipeline depth in cycles from accept to `fu_update.valid`. Legal range is 1..4.
- `FLEN`, 32: operand width. Only 32 is supported.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `valid`, input, 1: `input_data` carries an operation this cycle.
- `input_data`, input, `to_execution`: uses `data1`, `data2`, `microoperation`, `destination`, `ticket`.
- `flush`, input, 1: kills all in-flight operations.
- `busy_fu`, output, 1: unit cannot accept an operation this cycle.
- `fu_update`, output, `ex_update`: carries `valid`, `destination`, `ticket`, `data`, `valid_exception`, `cause`.

## Operation
- Micro-ops are FSGNJ, FSGNJN, FSGNJX, FMIN, FMAX, FEQ, FLT, FLE, FCLASS, FMVXW and FMVWX. Encodings live in the package.
- Sign-injection: result is {sign op, data1[30:0]}, where the sign op uses data2[31] directly, its inverse, or XOR with data1[31] respectively.
- FMIN/FMAX:
  - -0.0 orders below +0.0.
  - If exactly one operand is NaN, the result is the other operand.
  - If both are NaN, the result is the canonical NaN 32'h7FC0_0000.
- Compares write 32'h0 or 32'h1. Any NaN operand gives 0.
- FCLASS writes a one-hot 10-bit mask zero-extended to 32 bits. Bits 0..9 are: -inf, -normal, -subnormal, -0, +0, +subnormal, +normal, +inf, sNaN, qNaN.
- FMVXW and FMVWX pass `data1` unchanged.
- An unknown micro-op produces data 0 (plus an exception when the Configuration macro is defined).
- Result computation is combinational in stage 0. Stages 1..LATENCY-1 are pure delay registers carrying valid, destination, ticket, data and exception fields.
- An op is accepted when `valid && !busy_fu`.
- `busy_fu` is high while `rst_n` is low and in the cycle of `flush`; otherwise it is 0. The unit is fully pipelined and takes one op per cycle.
- `flush`:
  - Synchronously clears every stage valid bit, including the output stage.
  - An op presented in the same cycle as `flush` is dropped.
  - Flush has priority over accept.

## Timing
- Latency is exactly LATENCY cycles: an op accepted at edge N appears on `fu_update` during cycle N+LATENCY and is valid for exactly one cycle.
- Throughput is one result per cycle. Back-to-back ops keep their order, with no bubbles inserted.
- Reset (rst_n low at a clock edge):
  - All stage valids become 0.
  - `fu_update.valid`, `valid_exception`, `cause`, `destination`, `ticket` and `data` all become 0.
  - `busy_fu` is 1 while reset is held.
  - Reset mid-operation discards all in-flight ops; the first accept is possible in the first cycle with rst_n high.
- LATENCY=1: `fu_update` is driven directly from the stage-0 output register. There is no extra delay stage.
- The payload fields of an invalid stage hold their last value. Only `fu_update.valid` is meaningful when it is 0, except after reset, when all fields are zero.

## Configuration
- `FP_ALU_EXC_EN` defined:
  - Signaling-NaN input to FEQ/FMIN/FMAX, or any NaN input to FLT/FLE, sets `valid_exception`=1 with `cause`=`FP_CAUSE_INVALID`.
  - An unknown micro-op sets `valid_exception`=1 with `cause`=`FP_CAUSE_ILLEGAL`.
  - The result data is still written as specified in Operation.
- `FP_ALU_EXC_EN` undefined: `valid_exception` and `cause` are tied to 0, and the exception logic is not compiled.

## Structure
- The shared package holds:
  - Micro-op encodings: `FP_SGNJ`..`FP_MVWX`.
  - `FP_CANON_NAN`.
  - Cause constants `FP_CAUSE_INVALID` and `FP_CAUSE_ILLEGAL`.
  - The `fp_class_t` bit positions.
  - Pipeline stage struct `fp_pipe_stage` (valid, destination, ticket, data, valid_exception, cause).
- One sub-module, `fp_classify`: combinational decode of a 32-bit operand into the 10-bit class mask plus is_nan/is_snan/is_zero flags.
  - Instantiated twice, once per operand.
  - Reused by FCLASS, min/max and compare.

## Test plan
- FSGNJN with data1=32'h3F80_0000 and data2=32'h3F80_0000, LATENCY=2 → data=32'hBF80_0000, valid exactly 2 cycles after accept, ticket and destination echoed.
- FMIN(+0.0=32'h0000_0000, -0.0=32'h8000_0000) → 32'h8000_0000. FMAX(qNaN 32'h7FC0_0001, 32'h4000_0000) → 32'h4000_0000. FMAX(NaN, NaN) → 32'h7FC0_0000.
- FLT(sNaN 32'h7F80_0001, 1.0) → data 0. With `FP_ALU_EXC_EN`: `valid_exception`=1 and `cause`=`FP_CAUSE_INVALID`. Without the macro: `valid_exception`=0.
- FCLASS on each of 32'hFF80_0000, 32'h0000_0001, 32'h7F80_0001 → 32'h001, 32'h020, 32'h100.
- Four back-to-back ops with tickets 1..4, `flush` asserted in the cycle ticket 3 is accepted → tickets 1 and 2 are also killed if still in flight (LATENCY=2: ticket 1 already emitted, ticket 2 killed, ticket 3 dropped), ticket 4 completes normally.
- rst_n low for one cycle while three ops are in flight → no `fu_update.valid` afterwards, all outputs zero, `busy_fu`=1 during reset; an op accepted the next cycle completes with normal latency.

Source files
------------

// File: rtl/floating_alu_pipe_pkg.sv
// Shared types for the FP ALU pipe: micro-op encodings, class bits, causes, bus structs.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package floating_alu_pipe_pkg;

    localparam int INSTR_W = 32;

    typedef logic [3:0] fp_uop_t;

    localparam fp_uop_t FP_SGNJ  = 4'd0;
    localparam fp_uop_t FP_SGNJN = 4'd1;
    localparam fp_uop_t FP_SGNJX = 4'd2;
    localparam fp_uop_t FP_MIN   = 4'd3;
    localparam fp_uop_t FP_MAX   = 4'd4;
    localparam fp_uop_t FP_EQ    = 4'd5;
    localparam fp_uop_t FP_LT    = 4'd6;
    localparam fp_uop_t FP_LE    = 4'd7;
    localparam fp_uop_t FP_CLASS = 4'd8;
    localparam fp_uop_t FP_MVXW  = 4'd9;
    localparam fp_uop_t FP_MVWX  = 4'd10;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

    typedef logic [3:0] fp_cause_t;

    localparam fp_cause_t FP_CAUSE_ILLEGAL = 4'd1;
    localparam fp_cause_t FP_CAUSE_INVALID = 4'd2;

    // Bit positions inside the 10-bit class mask.
    typedef enum logic [3:0] {
        FP_CLS_NEG_INF  = 4'd0,
        FP_CLS_NEG_NORM = 4'd1,
        FP_CLS_NEG_SUB  = 4'd2,
        FP_CLS_NEG_ZERO = 4'd3,
        FP_CLS_POS_ZERO = 4'd4,
        FP_CLS_POS_SUB  = 4'd5,
        FP_CLS_POS_NORM = 4'd6,
        FP_CLS_POS_INF  = 4'd7,
        FP_CLS_SNAN     = 4'd8,
        FP_CLS_QNAN     = 4'd9
    } fp_class_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [31:0]        data1;
        logic [31:0]        data2;
        fp_uop_t            microoperation;
        logic [4:0]         destination;
        logic [7:0]         ticket;
    } to_execution;

    typedef struct packed {
        logic        valid;
        logic [4:0]  destination;
        logic [7:0]  ticket;
        logic [31:0] data;
        logic        valid_exception;
        fp_cause_t   cause;
    } ex_update;

    typedef struct packed {
        logic        valid;
        logic [4:0]  destination;
        logic [7:0]  ticket;
        logic [31:0] data;
        logic        valid_exception;
        fp_cause_t   cause;
    } fp_pipe_stage;

    // Total order on non-NaN values where -0.0 sorts below +0.0.
    function automatic logic fp_lt_ord(input logic [31:0] x, input logic [31:0] y);
        if (x[31] != y[31]) return x[31];
        if (x[31]) return x[30:0] > y[30:0];
        return x[30:0] < y[30:0];
    endfunction

endpackage

// File: rtl/floating_alu_pipe_if.sv
// Issue-side and writeback-side bus of the FP ALU pipe.
// Latency: n/a (wires only).
// Backpressure: busy_fu from the unit; master must hold off valid while it is high.
// master = issue logic / bench, slave = floating_alu_pipe.
interface floating_alu_pipe_if;
    import floating_alu_pipe_pkg::*;

    logic        valid;
    to_execution input_data;
    logic        flush;
    logic        busy_fu;
    ex_update    fu_update;

    modport master (output valid, input_data, flush, input busy_fu, fu_update);
    modport slave  (input valid, input_data, flush, output busy_fu, fu_update);
endinterface

// File: rtl/floating_alu_pipe_fp_classify.sv
// Combinational decode of a single-precision operand into a one-hot class mask.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: operand in; cls (10-bit one-hot), is_nan, is_snan, is_zero out.
module fp_classify
    import floating_alu_pipe_pkg::*;
(
    input  logic [31:0] operand,
    output logic [9:0]  cls,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_zero
);
    logic sign;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;

    assign sign     = operand[31];
    assign exp_ones = &operand[30:23];
    assign exp_zero = ~|operand[30:23];
    assign man_zero = ~|operand[22:0];

    assign is_nan  = exp_ones & ~man_zero;
    assign is_snan = is_nan & ~operand[22];
    assign is_zero = exp_zero & man_zero;

    always_comb begin
        cls = '0;
        if (exp_ones) begin
            if (man_zero)         cls[sign ? FP_CLS_NEG_INF : FP_CLS_POS_INF] = 1'b1;
            else if (operand[22]) cls[FP_CLS_QNAN] = 1'b1;
            else                  cls[FP_CLS_SNAN] = 1'b1;
        end else if (exp_zero) begin
            if (man_zero) cls[sign ? FP_CLS_NEG_ZERO : FP_CLS_POS_ZERO] = 1'b1;
            else          cls[sign ? FP_CLS_NEG_SUB  : FP_CLS_POS_SUB]  = 1'b1;
        end else begin
            cls[sign ? FP_CLS_NEG_NORM : FP_CLS_POS_NORM] = 1'b1;
        end
    end
endmodule

// File: rtl/floating_alu_pipe.sv
// Pipelined FP ALU: sign-injection, min/max, compare, classify, move.
// Latency: LATENCY cycles (1..4) from accept to fu_update.valid, one op per cycle.
// Backpressure: none while running; busy_fu only during reset and in the flush cycle.
// Ports: clk, rst_n (sync, active-low), io (slave: valid/input_data/flush in, busy_fu/fu_update out).
// Build option: FP_ALU_EXC_EN enables invalid/illegal exception reporting.
module floating_alu_pipe
    import floating_alu_pipe_pkg::*;
#(
    parameter int INSTR_BITS = INSTR_W,
    parameter int LATENCY    = 2,
    parameter int FLEN       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    floating_alu_pipe_if.slave io
);
    // Width parameters exist for struct compatibility only; the datapath is fixed at 32 bits.
    localparam int unused_cfg = INSTR_BITS + FLEN;

    logic [31:0]  a;
    logic [31:0]  b;
    logic [9:0]   cls_a;
    logic [9:0]   unused_cls_b;
    logic         a_nan, a_snan, a_zero;
    logic         b_nan, b_snan, b_zero;
    logic         a_lt_b;
    logic         any_nan;
    logic         eq;
    logic         accept;
    fp_pipe_stage res;
    fp_pipe_stage st [LATENCY];
    logic         unused_bits;

    assign a = io.input_data.data1;
    assign b = io.input_data.data2;

    fp_classify u_cls_a (.operand(a), .cls(cls_a),        .is_nan(a_nan), .is_snan(a_snan), .is_zero(a_zero));
    fp_classify u_cls_b (.operand(b), .cls(unused_cls_b), .is_nan(b_nan), .is_snan(b_snan), .is_zero(b_zero));

    assign unused_bits = ^{io.input_data.instruction, unused_cls_b, a_snan, b_snan};

    assign a_lt_b  = fp_lt_ord(a, b);
    assign any_nan = a_nan | b_nan;
    // +0 and -0 compare equal even though they differ bitwise.
    assign eq      = (a == b) || (a_zero && b_zero);

    assign io.busy_fu = !rst_n || io.flush;
    assign accept     = io.valid && !io.busy_fu;

    always_comb begin
        res             = '0;
        res.valid       = 1'b1;
        res.destination = io.input_data.destination;
        res.ticket      = io.input_data.ticket;
        case (io.input_data.microoperation)
            FP_SGNJ:  res.data = {b[31], a[30:0]};
            FP_SGNJN: res.data = {~b[31], a[30:0]};
            FP_SGNJX: res.data = {a[31] ^ b[31], a[30:0]};
            FP_MIN, FP_MAX: begin
                if (a_nan && b_nan)    res.data = FP_CANON_NAN;
                else if (a_nan)        res.data = b;
                else if (b_nan)        res.data = a;
                else if (io.input_data.microoperation == FP_MIN)
                                       res.data = a_lt_b ? a : b;
                else                   res.data = a_lt_b ? b : a;
            end
            FP_EQ:    res.data = {31'b0, !any_nan && eq};
            FP_LT:    res.data = {31'b0, !any_nan && a_lt_b && !(a_zero && b_zero)};
            FP_LE:    res.data = {31'b0, !any_nan && (a_lt_b || eq)};
            FP_CLASS: res.data = {22'b0, cls_a};
            FP_MVXW, FP_MVWX: res.data = a;
            default:  res.data = '0;
        endcase
`ifdef FP_ALU_EXC_EN
        case (io.input_data.microoperation)
            FP_EQ, FP_MIN, FP_MAX: begin
                if (a_snan || b_snan) begin
                    res.valid_exception = 1'b1;
                    res.cause           = FP_CAUSE_INVALID;
                end
            end
            FP_LT, FP_LE: begin
                if (any_nan) begin
                    res.valid_exception = 1'b1;
                    res.cause           = FP_CAUSE_INVALID;
                end
            end
            FP_SGNJ, FP_SGNJN, FP_SGNJX, FP_CLASS, FP_MVXW, FP_MVWX: ;
            default: begin
                res.valid_exception = 1'b1;
                res.cause           = FP_CAUSE_ILLEGAL;
            end
        endcase
`endif
    end

    // Valid bits always advance; payloads only move with a live op so idle stages keep their last contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) st[i] <= '0;
        end else begin
            st[0].valid <= accept;
            if (accept) st[0] <= res;
            for (int i = 1; i < LATENCY; i++) begin
                st[i].valid <= st[i-1].valid && !io.flush;
                if (st[i-1].valid && !io.flush) st[i] <= st[i-1];
            end
        end
    end

    assign io.fu_update.valid           = st[LATENCY-1].valid;
    assign io.fu_update.destination     = st[LATENCY-1].destination;
    assign io.fu_update.ticket          = st[LATENCY-1].ticket;
    assign io.fu_update.data            = st[LATENCY-1].data;
    assign io.fu_update.valid_exception = st[LATENCY-1].valid_exception;
    assign io.fu_update.cause           = st[LATENCY-1].cause;
endmodule

// File: tb/tb_floating_alu_pipe.sv
// Scoreboard bench for floating_alu_pipe: directed vectors, expected results queued at issue,
// compared by a negedge monitor whenever fu_update.valid is seen.
module tb_floating_alu_pipe;
    import floating_alu_pipe_pkg::*;

    localparam int LAT = 2;
`ifdef FP_ALU_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    floating_alu_pipe_if bus();

    floating_alu_pipe #(.INSTR_BITS(32), .LATENCY(LAT), .FLEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    typedef struct {
        logic [7:0]  ticket;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        vexc;
        fp_cause_t   cause;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid result must match the head of the scoreboard, on the expected cycle.
    always @(negedge clk) begin
        if (bus.fu_update.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: ticket %h data %h, expected no result", bus.fu_update.ticket, bus.fu_update.data);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("data_t%0d", mon_e.ticket), 64'(bus.fu_update.data), 64'(mon_e.data));
                check($sformatf("tag_t%0d", mon_e.ticket),
                      64'({bus.fu_update.ticket, bus.fu_update.destination}), 64'({mon_e.ticket, mon_e.dest}));
                check($sformatf("exc_t%0d", mon_e.ticket),
                      64'({bus.fu_update.valid_exception, bus.fu_update.cause}), 64'({mon_e.vexc, mon_e.cause}));
                check($sformatf("cycle_t%0d", mon_e.ticket), 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Present one op for one edge. ecause is the cause expected when exceptions are compiled in (0 = none).
    task automatic issue(input fp_uop_t op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [7:0] tkt, input logic [31:0] edata, input fp_cause_t ecause,
                         input bit expect_out, input bit with_flush);
        exp_t e;
        bus.valid                     = 1'b1;
        bus.input_data.instruction    = {24'h0, tkt};
        bus.input_data.data1          = d1;
        bus.input_data.data2          = d2;
        bus.input_data.microoperation = op;
        bus.input_data.ticket         = tkt;
        bus.input_data.destination    = tkt[4:0] ^ 5'h1F;
        bus.flush                     = with_flush;
        if (with_flush) begin
            #1;
            check("busy_on_flush", 64'(bus.busy_fu), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.flush = 1'b0;
        if (expect_out) begin
            e.ticket = tkt;
            e.dest   = tkt[4:0] ^ 5'h1F;
            e.data   = edata;
            e.vexc   = EXC_EN && (ecause != 4'd0);
            e.cause  = EXC_EN ? ecause : 4'd0;
            e.due    = cyc + LAT - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.valid      = 1'b0;
        bus.flush      = 1'b0;
        bus.input_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_in_reset", 64'(bus.busy_fu), 64'd1);
        check("out_after_reset", 64'(bus.fu_update), 64'd0);
        rst_n = 1'b1;
        #1;
        check("busy_idle", 64'(bus.busy_fu), 64'd0);

        // Sign injection and moves
        issue(FP_SGNJN, 32'h3F80_0000, 32'h3F80_0000, 8'd1,  32'hBF80_0000, 4'd0, 1, 0);
        issue(FP_SGNJ,  32'h3F80_0000, 32'hBF80_0000, 8'd2,  32'hBF80_0000, 4'd0, 1, 0);
        issue(FP_SGNJX, 32'hBF80_0000, 32'hBF80_0000, 8'd3,  32'h3F80_0000, 4'd0, 1, 0);
        issue(FP_MVXW,  32'h1234_5678, 32'h0,         8'd4,  32'h1234_5678, 4'd0, 1, 0);
        // Min / max
        issue(FP_MIN,   32'h0000_0000, 32'h8000_0000, 8'd5,  32'h8000_0000, 4'd0, 1, 0);
        issue(FP_MAX,   32'h7FC0_0001, 32'h4000_0000, 8'd6,  32'h4000_0000, 4'd0, 1, 0);
        issue(FP_MAX,   32'h7FC0_0000, 32'h7F80_0001, 8'd7,  32'h7FC0_0000, FP_CAUSE_INVALID, 1, 0);
        issue(FP_MAX,   32'hC000_0000, 32'hBF80_0000, 8'd8,  32'hBF80_0000, 4'd0, 1, 0);
        issue(FP_MIN,   32'h7F80_0001, 32'h3F80_0000, 8'd9,  32'h3F80_0000, FP_CAUSE_INVALID, 1, 0);
        // Compares
        issue(FP_LT,    32'h7F80_0001, 32'h3F80_0000, 8'd10, 32'h0,         FP_CAUSE_INVALID, 1, 0);
        issue(FP_EQ,    32'h0000_0000, 32'h8000_0000, 8'd11, 32'h1,         4'd0, 1, 0);
        issue(FP_LE,    32'h3F80_0000, 32'h3F80_0000, 8'd12, 32'h1,         4'd0, 1, 0);
        issue(FP_LT,    32'hBF80_0000, 32'h3F80_0000, 8'd13, 32'h1,         4'd0, 1, 0);
        issue(FP_LT,    32'h8000_0000, 32'h0000_0000, 8'd14, 32'h0,         4'd0, 1, 0);
        issue(FP_EQ,    32'h7FC0_0000, 32'h7FC0_0000, 8'd15, 32'h0,         4'd0, 1, 0);
        issue(FP_LE,    32'h7FC0_0000, 32'h0000_0000, 8'd16, 32'h0,         FP_CAUSE_INVALID, 1, 0);
        // Classify
        issue(FP_CLASS, 32'hFF80_0000, 32'h0, 8'd17, 32'h0000_0001, 4'd0, 1, 0);
        issue(FP_CLASS, 32'h0000_0001, 32'h0, 8'd18, 32'h0000_0020, 4'd0, 1, 0);
        issue(FP_CLASS, 32'h7F80_0001, 32'h0, 8'd19, 32'h0000_0100, 4'd0, 1, 0);
        issue(FP_CLASS, 32'h8000_0000, 32'h0, 8'd20, 32'h0000_0008, 4'd0, 1, 0);
        issue(FP_CLASS, 32'h7FC0_0000, 32'h0, 8'd21, 32'h0000_0200, 4'd0, 1, 0);
        issue(FP_CLASS, 32'h3F80_0000, 32'h0, 8'd22, 32'h0000_0040, 4'd0, 1, 0);
        // Unknown micro-op
        issue(4'hF,     32'hDEAD_BEEF, 32'h1, 8'd23, 32'h0, FP_CAUSE_ILLEGAL, 1, 0);
        drain();

        // Flush in the cycle ticket 3 is presented; op k (accepted k edges before) survives only if already out.
        issue(FP_MVXW, 32'h0000_00A1, 32'h0, 8'd1, 32'h0000_00A1, 4'd0, (1 + LAT - 1 < 3), 0);
        issue(FP_MVXW, 32'h0000_00A2, 32'h0, 8'd2, 32'h0000_00A2, 4'd0, (2 + LAT - 1 < 3), 0);
        issue(FP_MVXW, 32'h0000_00A3, 32'h0, 8'd3, 32'h0000_00A3, 4'd0, 0, 1);
        issue(FP_MVXW, 32'h0000_00A4, 32'h0, 8'd4, 32'h0000_00A4, 4'd0, 1, 0);
        drain();

        // Reset while ops are in flight; only those already emitted before the reset edge are seen.
        issue(FP_MVWX, 32'h0000_00B1, 32'h0, 8'd31, 32'h0000_00B1, 4'd0, (1 + LAT - 1 < 4), 0);
        issue(FP_MVWX, 32'h0000_00B2, 32'h0, 8'd32, 32'h0000_00B2, 4'd0, (2 + LAT - 1 < 4), 0);
        issue(FP_MVWX, 32'h0000_00B3, 32'h0, 8'd33, 32'h0000_00B3, 4'd0, (3 + LAT - 1 < 4), 0);
        rst_n = 1'b0;
        #1;
        check("busy_mid_reset", 64'(bus.busy_fu), 64'd1);
        @(posedge clk);
        #1;
        check("out_mid_reset", 64'(bus.fu_update), 64'd0);
        check("busy_mid_reset_held", 64'(bus.busy_fu), 64'd1);
        rst_n = 1'b1;
        #1;
        check("busy_after_reset", 64'(bus.busy_fu), 64'd0);
        issue(FP_SGNJN, 32'h4000_0000, 32'h0000_0000, 8'd40, 32'hC000_0000, 4'd0, 1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
